pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Central pipeline sequencer for the MIPS core.
- Generates per-stage Local control (Stall, Flush) for the IF/ID, ID/EX, EX/MEM and MEM/WB registers, plus PC_Stall.
- Covers load-use hazards, the multi-cycle HI/LO unit, branch/jump redirects resolved in EX, and I/D cache misses.
- Holds a mult/div busy counter and a squash flag for redirects that arrive during an I-miss.

Parameters:
- REG_W, 5, register specifier width
- MUL_LAT, 4, multiply latency in cycles (≥1)
- DIV_LAT, 32, divide latency in cycles (≥1)
- CNT_W, 6, busy counter width; must satisfy 2^CNT_W > max(MUL_LAT, DIV_LAT)

Ports:
- System  input  Global  struct carrying Clk and Rst; one clock, Rst synchronous active-high
- IMiss  input  1  I-cache miss; fetched instruction invalid this cycle
- DMiss  input  1  D-cache miss; MEM stage cannot complete
- ID_Rs  input  REG_W  rs of instruction in ID
- ID_Rt  input  REG_W  rt of instruction in ID
- ID_UseRt  input  1  ID instruction reads rt
- ID_MDUse  input  1  ID instruction is mult/div/mfhi/mflo/mthi/mtlo
- EX_MemRead  input  1  EX instruction is a load
- EX_Rd  input  REG_W  EX destination register
- EX_MDStart  input  1  EX issues mult/div this cycle
- EX_MDOp  input  1  0 = mult, 1 = div
- EX_Redirect  input  1  EX resolved taken branch, jump or mispredict
- IF_ID_Cntl  output  Local  {Stall, Flush} for IF/ID
- ID_EX_Cntl  output  Local  for ID/EX
- EX_MEM_Cntl  output  Local  for EX/MEM
- MEM_WB_Cntl  output  Local  for MEM/WB
- PC_Stall  output  1  hold PC
- MD_Busy  output  1  HI/LO unit busy

Behaviour:
- **Outputs and state timing**
  - Control outputs are combinational from inputs and registered state, so stalls take effect in the same cycle.
  - State is the MD FSM, the busy counter and the Squash flag.
- **Reset**
  - While Rst=1: all four Cntl = {Stall 0, Flush 1}; PC_Stall=0; MD_Busy=0.
  - On the next edge: MD FSM → IDLE, counter → 0, Squash → 0.
  - Rst mid-divide aborts the divide with no residue.
- **Priority (highest first)**
  1. Rst
  2. DMiss
  3. EX_Redirect
  4. ID hazard (load-use or MD)
  5. IMiss / Squash
  6. Normal
- **DMiss**
  - IF_ID, ID_EX and EX_MEM Stall=1; MEM_WB Flush=1 (bubble to WB); PC_Stall=1.
  - EX_Redirect is ignored; it remains asserted because EX is frozen and is acted on after DMiss falls.
  - EX_MDStart is ignored while DMiss=1.
  - MD counter keeps counting.
- **EX_Redirect (no DMiss)**
  - IF_ID Flush=1, ID_EX Flush=1, PC_Stall=0 (PC loads target).
  - If IMiss=1 in the same cycle, set Squash=1.
- **Load-use hazard**
  - Condition: EX_MemRead & EX_Rd≠0 & (EX_Rd==ID_Rs | (ID_UseRt & EX_Rd==ID_Rt)).
- **MD hazard**
  - Condition: ID_MDUse & (MD_Busy | EX_MDStart).
- **Response to either ID hazard**
  - PC_Stall=1, IF_ID Stall=1, ID_EX Flush=1.
  - This overrides the IMiss IF_ID flush.
- **IMiss or Squash (no higher event)**
  - PC_Stall=IMiss; IF_ID Flush=1.
- **Squash**
  - Squash clears on the first cycle with IMiss=0 and no DMiss; that cycle flushes IF_ID (stale target-less fetch dropped).
  - A new EX_Redirect with IMiss=1 keeps Squash=1.
- **MD FSM**
  - IDLE: EX_MDStart & !DMiss → BUSY, counter = (EX_MDOp ? DIV_LAT : MUL_LAT) − 1.
  - BUSY: counter decrements every cycle; counter==0 → IDLE.
  - MD_Busy = (state==BUSY).
  - EX_MDStart while BUSY cannot occur, because the ID hazard prevents it; if it is asserted anyway, it is ignored.
- **Default**
  - All Cntl = {0, 0}; PC_Stall=0.
- **Invariant**
  - Never drive Stall and Flush both to 1 on one Local.

Decomposition:
- System_Pkg holds Global and Local.
- Add to System_Pkg: MD_IDLE/MD_BUSY enum, default MUL_LAT/DIV_LAT constants, and a Local constant CNTL_NOP = '0.
- One sub-module, md_busy_ctr: holds the FSM and counter and outputs MD_Busy.
- Hazard priority logic stays in the top level.

Test Plan:
- Load-use: EX_MemRead=1, EX_Rd=8, ID_Rs=8 → one cycle of PC_Stall=1, IF_ID.Stall=1, ID_EX.Flush=1. With EX_Rd=0 → no stall.
- Divide: EX_MDStart=1, EX_MDOp=1 → MD_Busy high for exactly 32 cycles. An mfhi in ID during that window stalls until the cycle MD_Busy falls.
- DMiss for 3 cycles with EX_Redirect=1 → 3 cycles of IF_ID/ID_EX/EX_MEM Stall=1 and MEM_WB Flush=1. Redirect flush occurs in cycle 4.
- Redirect during IMiss: EX_Redirect=1, IMiss=1 → IF_ID and ID_EX Flush, Squash=1. When IMiss falls, one further IF_ID Flush, then normal.
- Load-use concurrent with IMiss → IF_ID.Stall=1 (not Flush), ID_EX.Flush=1.
- Rst asserted in the middle of a divide → all Flush=1, MD_Busy=0 on the next cycle, counter idle.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Pipeline register control word, global clock/reset bundle, mult/div FSM states.
package pipe_hazard_ctrl_pkg;

  localparam int unsigned MUL_LAT_DEF = 4;
  localparam int unsigned DIV_LAT_DEF = 32;

  typedef struct packed {
    logic clk;
    logic rst;
  } global_t;

  typedef struct packed {
    logic stall;
    logic flush;
  } local_t;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_t;

  localparam local_t CNTL_NOP   = '0;
  localparam local_t CNTL_STALL = '{stall: 1'b1, flush: 1'b0};
  localparam local_t CNTL_FLUSH = '{stall: 1'b0, flush: 1'b1};

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline status in, per-stage register control out.
// master = datapath side, slave = hazard controller side.
interface pipe_hazard_ctrl_if #(
  parameter int unsigned REG_W = 5
);
  import pipe_hazard_ctrl_pkg::*;

  logic             imiss;
  logic             dmiss;
  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic             id_use_rt;
  logic             id_md_use;
  logic             ex_mem_read;
  logic [REG_W-1:0] ex_rd;
  logic             ex_md_start;
  logic             ex_md_op;
  logic             ex_redirect;

  local_t           if_id_cntl;
  local_t           id_ex_cntl;
  local_t           ex_mem_cntl;
  local_t           mem_wb_cntl;
  logic             pc_stall;
  logic             md_busy;

  modport master (
    output imiss, dmiss, id_rs, id_rt, id_use_rt, id_md_use,
           ex_mem_read, ex_rd, ex_md_start, ex_md_op, ex_redirect,
    input  if_id_cntl, id_ex_cntl, ex_mem_cntl, mem_wb_cntl, pc_stall, md_busy
  );

  modport slave (
    input  imiss, dmiss, id_rs, id_rt, id_use_rt, id_md_use,
           ex_mem_read, ex_rd, ex_md_start, ex_md_op, ex_redirect,
    output if_id_cntl, id_ex_cntl, ex_mem_cntl, mem_wb_cntl, pc_stall, md_busy
  );

endinterface

// File: rtl/pipe_hazard_ctrl_md_busy_ctr.sv
// HI/LO unit occupancy tracker: loads latency-1 on issue, counts down to idle.
// Counts regardless of pipeline freezes since the unit runs independently.
module md_busy_ctr
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned MUL_LAT = MUL_LAT_DEF,
  parameter int unsigned DIV_LAT = DIV_LAT_DEF,
  parameter int unsigned CNT_W   = 6
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic op,
  output logic busy
);

  md_state_t          state_q;
  logic [CNT_W-1:0]   cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        MD_IDLE: begin
          if (start) begin
            state_q <= MD_BUSY;
            cnt_q   <= op ? CNT_W'(DIV_LAT - 1) : CNT_W'(MUL_LAT - 1);
          end
        end
        MD_BUSY: begin
          // a start while busy is blocked upstream; ignore it here
          if (cnt_q == '0) state_q <= MD_IDLE;
          else             cnt_q   <= cnt_q - CNT_W'(1);
        end
        default: state_q <= MD_IDLE;
      endcase
    end
  end

  assign busy = (state_q == MD_BUSY);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central pipeline sequencer: per-stage stall/flush and PC hold from
// load-use, HI/LO occupancy, EX redirects and I/D cache misses.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned REG_W   = 5,
  parameter int unsigned MUL_LAT = MUL_LAT_DEF,
  parameter int unsigned DIV_LAT = DIV_LAT_DEF,
  parameter int unsigned CNT_W   = 6
) (
  input global_t              system,
  pipe_hazard_ctrl_if.slave   bus
);

  logic   rst;
  logic   md_busy_q;
  logic   md_start;
  logic   load_use;
  logic   md_haz;
  logic   squash_q;
  logic   squash_d;
  local_t if_id_c;
  local_t id_ex_c;
  local_t ex_mem_c;
  local_t mem_wb_c;
  logic   pc_stall_c;

  assign rst = system.rst;

  // mult/div issue is dropped while MEM is frozen
  assign md_start = bus.ex_md_start & ~bus.dmiss;

  md_busy_ctr #(
    .MUL_LAT (MUL_LAT),
    .DIV_LAT (DIV_LAT),
    .CNT_W   (CNT_W)
  ) u_md_busy_ctr (
    .clk   (system.clk),
    .rst   (rst),
    .start (md_start),
    .op    (bus.ex_md_op),
    .busy  (md_busy_q)
  );

  assign load_use = bus.ex_mem_read && (bus.ex_rd != '0) &&
                    ((bus.ex_rd == bus.id_rs) ||
                     (bus.id_use_rt && (bus.ex_rd == bus.id_rt)));
  assign md_haz   = bus.id_md_use && (md_busy_q || bus.ex_md_start);

  // priority: reset > dmiss > redirect > ID hazard > imiss/squash > normal
  always_comb begin
    if_id_c    = CNTL_NOP;
    id_ex_c    = CNTL_NOP;
    ex_mem_c   = CNTL_NOP;
    mem_wb_c   = CNTL_NOP;
    pc_stall_c = 1'b0;
    squash_d   = squash_q;
    if (rst) begin
      if_id_c  = CNTL_FLUSH;
      id_ex_c  = CNTL_FLUSH;
      ex_mem_c = CNTL_FLUSH;
      mem_wb_c = CNTL_FLUSH;
      squash_d = 1'b0;
    end else if (bus.dmiss) begin
      if_id_c    = CNTL_STALL;
      id_ex_c    = CNTL_STALL;
      ex_mem_c   = CNTL_STALL;
      mem_wb_c   = CNTL_FLUSH;
      pc_stall_c = 1'b1;
    end else if (bus.ex_redirect) begin
      if_id_c  = CNTL_FLUSH;
      id_ex_c  = CNTL_FLUSH;
      // an outstanding miss belongs to the old path; drop its fill later
      squash_d = bus.imiss;
    end else if (load_use || md_haz) begin
      if_id_c    = CNTL_STALL;
      id_ex_c    = CNTL_FLUSH;
      pc_stall_c = 1'b1;
    end else if (bus.imiss || squash_q) begin
      if_id_c    = CNTL_FLUSH;
      pc_stall_c = bus.imiss;
      if (!bus.imiss) squash_d = 1'b0;
    end
  end

  always_ff @(posedge system.clk) begin
    if (rst) squash_q <= 1'b0;
    else     squash_q <= squash_d;
  end

  assign bus.if_id_cntl  = if_id_c;
  assign bus.id_ex_cntl  = id_ex_c;
  assign bus.ex_mem_cntl = ex_mem_c;
  assign bus.mem_wb_cntl = mem_wb_c;
  assign bus.pc_stall    = pc_stall_c;
  assign bus.md_busy     = md_busy_q & ~rst;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: single-cycle vector table plus
// multi-cycle sequences (divide, multiply, dmiss, squash, reset mid-divide).
module tb_pipe_hazard_ctrl;
  import pipe_hazard_ctrl_pkg::*;

  // {if_id s,f, id_ex s,f, ex_mem s,f, mem_wb s,f, pc_stall, md_busy}
  localparam logic [9:0] E_NORM  = 10'b00_00_00_00_0_0;
  localparam logic [9:0] E_HAZ   = 10'b10_01_00_00_1_0;
  localparam logic [9:0] E_HAZB  = 10'b10_01_00_00_1_1;
  localparam logic [9:0] E_BUSY  = 10'b00_00_00_00_0_1;
  localparam logic [9:0] E_DMISS = 10'b10_10_10_01_1_0;
  localparam logic [9:0] E_REDIR = 10'b01_01_00_00_0_0;
  localparam logic [9:0] E_IMISS = 10'b01_00_00_00_1_0;
  localparam logic [9:0] E_SQ    = 10'b01_00_00_00_0_0;
  localparam logic [9:0] E_RST   = 10'b01_01_01_01_0_0;

  typedef struct {
    string      name;
    logic       imiss, dmiss, use_rt, md_use, mem_read, md_start, md_op, redirect;
    logic [4:0] rs, rt, rd;
    logic [9:0] exp;
  } vec_t;

  global_t sys;
  int      checks = 0;
  int      errors = 0;
  vec_t    vecs[$];

  pipe_hazard_ctrl_if #(.REG_W(5)) bus ();

  pipe_hazard_ctrl #(
    .REG_W(5), .MUL_LAT(4), .DIV_LAT(32), .CNT_W(6)
  ) dut (
    .system (sys),
    .bus    (bus)
  );

  always #5 sys.clk = ~sys.clk;

  function automatic vec_t mk(string n, logic im, logic dm, logic ur, logic mu,
                              logic mr, logic ms, logic mo, logic rdr,
                              logic [4:0] rs, logic [4:0] rt, logic [4:0] rd,
                              logic [9:0] e);
    vec_t v;
    v.name = n; v.imiss = im; v.dmiss = dm; v.use_rt = ur; v.md_use = mu;
    v.mem_read = mr; v.md_start = ms; v.md_op = mo; v.redirect = rdr;
    v.rs = rs; v.rt = rt; v.rd = rd; v.exp = e;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    bus.imiss = v.imiss;       bus.dmiss = v.dmiss;
    bus.id_use_rt = v.use_rt;  bus.id_md_use = v.md_use;
    bus.ex_mem_read = v.mem_read;
    bus.ex_md_start = v.md_start; bus.ex_md_op = v.md_op;
    bus.ex_redirect = v.redirect;
    bus.id_rs = v.rs; bus.id_rt = v.rt; bus.ex_rd = v.rd;
  endtask

  task automatic check(input string name, input logic [9:0] exp);
    logic [9:0] act;
    act = {bus.if_id_cntl, bus.id_ex_cntl, bus.ex_mem_cntl, bus.mem_wb_cntl,
           bus.pc_stall, bus.md_busy};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // settle after driving, compare, then advance to just past the next edge
  task automatic cyc(input string name, input logic [9:0] exp);
    #2;
    check(name, exp);
    @(posedge sys.clk); #1;
  endtask

  task automatic idle_inputs();
    drive(mk("idle", 0,0,0,0, 0,0,0,0, 5'd0, 5'd0, 5'd0, E_NORM));
  endtask

  initial begin
    sys.clk = 1'b0;
    sys.rst = 1'b1;
    idle_inputs();

    vecs.push_back(mk("normal",      0,0,0,0, 1,0,0,0, 5'd8, 5'd9, 5'd10, E_NORM));
    vecs.push_back(mk("lu_rs",       0,0,0,0, 1,0,0,0, 5'd8, 5'd9, 5'd8,  E_HAZ));
    vecs.push_back(mk("lu_rt",       0,0,1,0, 1,0,0,0, 5'd3, 5'd9, 5'd9,  E_HAZ));
    vecs.push_back(mk("rt_unused",   0,0,0,0, 1,0,0,0, 5'd3, 5'd9, 5'd9,  E_NORM));
    vecs.push_back(mk("lu_rd0",      0,0,1,0, 1,0,0,0, 5'd0, 5'd0, 5'd0,  E_NORM));
    vecs.push_back(mk("no_load",     0,0,0,0, 0,0,0,0, 5'd8, 5'd9, 5'd8,  E_NORM));
    vecs.push_back(mk("dmiss",       0,1,0,0, 0,0,0,0, 5'd1, 5'd2, 5'd3,  E_DMISS));
    vecs.push_back(mk("dmiss_redir", 0,1,0,0, 0,0,0,1, 5'd1, 5'd2, 5'd3,  E_DMISS));
    vecs.push_back(mk("dmiss_md",    0,1,0,1, 0,1,1,0, 5'd1, 5'd2, 5'd3,  E_DMISS));
    vecs.push_back(mk("after_dm_md", 0,0,0,0, 0,0,0,0, 5'd1, 5'd2, 5'd3,  E_NORM));
    vecs.push_back(mk("redir",       0,0,0,0, 0,0,0,1, 5'd1, 5'd2, 5'd3,  E_REDIR));
    vecs.push_back(mk("redir_lu",    0,0,0,0, 1,0,0,1, 5'd8, 5'd2, 5'd8,  E_REDIR));
    vecs.push_back(mk("imiss",       1,0,0,0, 0,0,0,0, 5'd1, 5'd2, 5'd3,  E_IMISS));
    vecs.push_back(mk("lu_imiss",    1,0,0,0, 1,0,0,0, 5'd8, 5'd2, 5'd8,  E_HAZ));
    vecs.push_back(mk("dmiss_imiss", 1,1,0,0, 0,0,0,0, 5'd1, 5'd2, 5'd3,  E_DMISS));
    vecs.push_back(mk("idle_end",    0,0,0,0, 0,0,0,0, 5'd1, 5'd2, 5'd3,  E_NORM));

    // reset: outputs forced before and after the first edge
    #2 check("rst_pre", E_RST);
    @(posedge sys.clk); #1;
    check("rst_post", E_RST);
    @(posedge sys.clk); #1;
    sys.rst = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i]);
      cyc(vecs[i].name, vecs[i].exp);
    end

    // divide with mfhi waiting in ID: stalls through issue + 32 busy cycles
    idle_inputs();
    bus.ex_md_start = 1'b1; bus.ex_md_op = 1'b1; bus.id_md_use = 1'b1;
    cyc("div_issue", E_HAZ);
    bus.ex_md_start = 1'b0;
    for (int i = 0; i < 32; i++) cyc($sformatf("div_busy%0d", i), E_HAZB);
    cyc("div_done", E_NORM);

    // multiply: busy exactly 4 cycles
    idle_inputs();
    bus.ex_md_start = 1'b1; bus.ex_md_op = 1'b0;
    cyc("mul_issue", E_NORM);
    bus.ex_md_start = 1'b0;
    for (int i = 0; i < 4; i++) cyc($sformatf("mul_busy%0d", i), E_BUSY);
    cyc("mul_done", E_NORM);

    // dmiss holds off a pending redirect for 3 cycles
    idle_inputs();
    bus.dmiss = 1'b1; bus.ex_redirect = 1'b1;
    for (int i = 0; i < 3; i++) cyc($sformatf("dm_hold%0d", i), E_DMISS);
    bus.dmiss = 1'b0;
    cyc("dm_redir", E_REDIR);
    bus.ex_redirect = 1'b0;
    cyc("dm_after", E_NORM);

    // redirect during imiss: one extra IF/ID flush once the miss resolves
    idle_inputs();
    bus.imiss = 1'b1; bus.ex_redirect = 1'b1;
    cyc("sq_redir", E_REDIR);
    bus.ex_redirect = 1'b0;
    cyc("sq_miss", E_IMISS);
    bus.imiss = 1'b0;
    cyc("sq_flush", E_SQ);
    cyc("sq_clear", E_NORM);

    // reset in the middle of a divide leaves no residue
    idle_inputs();
    bus.ex_md_start = 1'b1; bus.ex_md_op = 1'b1;
    cyc("rd_issue", E_NORM);
    bus.ex_md_start = 1'b0;
    for (int i = 0; i < 5; i++) cyc($sformatf("rd_busy%0d", i), E_BUSY);
    sys.rst = 1'b1;
    cyc("rd_rst", E_RST);
    sys.rst = 1'b0;
    bus.id_md_use = 1'b1;
    cyc("rd_idle0", E_NORM);
    cyc("rd_idle1", E_NORM);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
